// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Main controller for the multi-cycle MIPS datapath. It sequences the shared
//   ALU, the register file, the instruction register and the unified memory
//   through the phases of each instruction. It decodes lw, sw, R-type, beq,
//   addi and j, and flags any other opcode as illegal.
//
//   The controller stalls in FETCH, MEMRD and MEMWR until MemReady is seen. A
//   wait counter aborts the access to FETCH after MEM_TIMEOUT stalled cycles.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   Opcode[5:0]      IR[31:26], valid from DECODE onward
//   MemReady         memory completes the current access this cycle
//   MemRead/MemWrite memory requests
//   IRWrite/PCWrite  IR load / unconditional PC load (FETCH: gated by MemReady)
//   Branch           PC load qualified by Zero in the datapath
//   RegWrite         register file write
//   IorD, MemtoReg, RegDst, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0]
//                    datapath mux selects and ALU operation class
//   MemFault         one-cycle pulse on memory timeout
//   IllegalOp        one-cycle pulse on unknown opcode in DECODE
//   State[3:0]       current state encoding for debug (0 while reset=1)
//
// state   | meaning
// --------+----------------------------------------------------
// FETCH   | read instruction at PC, PC <= PC+4 on MemReady
// DECODE  | read registers, compute branch target into ALUOut
// MEMADR  | compute load/store address A + SignImm
// MEMRD   | read data memory at ALUOut
// MEMWB   | write MDR to rt
// MEMWR   | write B to data memory at ALUOut
// EXECUTE | R-type ALU operation on A, B
// ALUWB   | write ALUOut to rd
// BRANCH  | compare A, B and load branch target if equal
// ADDIEX  | compute A + SignImm
// ADDIWB  | write ALUOut to rt
// JUMP    | load jump target into PC
// 12..15  | unreachable, return to FETCH with outputs idle

module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       RegWrite,
    output logic       IorD,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       MemFault,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_state;
    logic             timeout;

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);

    // MemReady wins over a timeout landing on the same cycle.
    assign timeout = wait_state && !MemReady && (wait_cnt == TIMEOUT_VAL);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter. A FETCH abort returns to FETCH without a state change,
    // so the timeout itself also clears the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((state_d != state_q) || timeout) begin
            wait_cnt <= '0;
        end else if (wait_state && !MemReady) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                if (MemReady)     state_d = S_DECODE;
                else              state_d = S_FETCH;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Opcode == OP_SW) state_d = S_MEMWR;
                else                 state_d = S_MEMRD;
            end
            S_MEMRD: begin
                if (MemReady)     state_d = S_MEMWB;
                else if (timeout) state_d = S_FETCH;
                else              state_d = S_MEMRD;
            end
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR: begin
                if (MemReady)     state_d = S_FETCH;
                else if (timeout) state_d = S_FETCH;
                else              state_d = S_MEMWR;
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Output logic. Everything is forced idle while reset is high so that a
    // reset landing on a writeback state cannot commit a partial result.
    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        Branch    = 1'b0;
        RegWrite  = 1'b0;
        IorD      = 1'b0;
        MemtoReg  = 1'b0;
        RegDst    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        PCSrc     = 2'b00;
        MemFault  = 1'b0;
        IllegalOp = 1'b0;
        State     = 4'd0;
        if (!reset) begin
            State    = state_q;
            MemFault = timeout;
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    case (Opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J:
                                 IllegalOp = 1'b0;
                        default: IllegalOp = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b01;
                    Branch  = 1'b1;
                    PCSrc   = 2'b01;
                end
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_ADDIWB: begin
                    RegWrite = 1'b1;
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b10;
                end
                default: begin
                    MemFault = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    localparam int TMO = 15;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ILL  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       MemRead, MemWrite, IRWrite, PCWrite, Branch, RegWrite;
    logic       IorD, MemtoReg, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       MemFault, IllegalOp;
    logic [3:0] State;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .Branch(Branch), .RegWrite(RegWrite),
        .IorD(IorD), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .MemFault(MemFault), .IllegalOp(IllegalOp), .State(State)
    );

    logic [21:0] obs;
    assign obs = {MemRead, MemWrite, IRWrite, PCWrite, Branch, RegWrite,
                  IorD, MemtoReg, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
                  MemFault, IllegalOp, State};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic rdy);
        reset    = r;
        Opcode   = op;
        MemReady = rdy;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit legal(input logic [5:0] op);
        return op inside {LW, SW, RT, BEQ, ADDI, JMP};
    endfunction

    function automatic bit is_mem(input int st);
        return st == 0 || st == 3 || st == 5;
    endfunction

    // Each instruction is a fixed walk through states, back to FETCH at the end.
    function automatic int next_in_path(input logic [5:0] op, input int st);
        int path[$];
        case (op)
            LW:      path = '{0, 1, 2, 3, 4};
            SW:      path = '{0, 1, 2, 5};
            RT:      path = '{0, 1, 6, 7};
            BEQ:     path = '{0, 1, 8};
            ADDI:    path = '{0, 1, 9, 10};
            JMP:     path = '{0, 1, 11};
            default: path = '{0, 1};
        endcase
        for (int i = 0; i < path.size(); i++)
            if (path[i] == st) return (i + 1 < path.size()) ? path[i+1] : 0;
        return 0;
    endfunction

    function automatic logic [21:0] model_out(input int st, input logic rst,
            input logic [5:0] op, input logic rdy, input int w);
        logic mr, mw, irw, pcw, br, rw, iord, m2r, rdst, asa, flt, ill;
        logic [1:0] asb, aop, pcs;
        {mr, mw, irw, pcw, br, rw, iord, m2r, rdst, asa, flt, ill} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        if (rst) return '0;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin asb = 2'b11; ill = !legal(op); end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b01; br = 1; pcs = 2'b01; end
            9:  begin asa = 1; asb = 2'b10; end
            10: begin rw = 1; end
            11: begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        flt = is_mem(st) && !rdy && (w == TMO);
        return {mr, mw, irw, pcw, br, rw, iord, m2r, rdst, asa, asb, aop, pcs,
                flt, ill, 4'(st)};
    endfunction

    int m_st, m_wait;

    task automatic model_step(input logic rst, input logic [5:0] op, input logic rdy);
        if (rst) begin
            m_st = 0; m_wait = 0;
        end else if (is_mem(m_st) && !rdy) begin
            if (m_wait == TMO) begin m_st = 0; m_wait = 0; end
            else m_wait++;
        end else begin
            m_st = next_in_path(op, m_st);
            m_wait = 0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        logic [1:0] aop;
        logic [1:0] pcs;
        logic       rw;
        logic       pcw;
        logic       br;
        logic       ill;
    } vec_t;

    vec_t tbl[$];

    task automatic go_to(input logic [5:0] op, input int target);
        for (int i = 0; i < 20; i++) begin
            if (State == 4'(target)) break;
            drive(0, op, 1);
            tick();
        end
        check($sformatf("reach_state_%0d", target), 32'(State), 32'(target));
    endtask

    task automatic stall_until_fault(input string name, input logic [5:0] op,
                                     input int exp_state, input int exp_idx);
        int idx, fidx, nf, bad;
        idx = 0; fidx = -1; nf = 0; bad = 0;
        while (State == 4'(exp_state) && idx < 40) begin
            drive(0, op, 0);
            if (MemFault) begin nf++; fidx = idx; end
            if (exp_state == 5 && !MemWrite) bad++;
            if (exp_state == 0 && (IRWrite || PCWrite)) bad++;
            tick();
            idx++;
            if (nf > 0) break;
        end
        check({name, "_fault_idx"}, 32'(fidx), 32'(exp_idx));
        check({name, "_fault_count"}, 32'(nf), 32'd1);
        check({name, "_enables"}, 32'(bad), 32'd0);
        check({name, "_next_state"}, 32'(State), 32'd0);
    endtask

    initial begin
        logic [11:0] got, want;
        int cyc, n3, stray, saw4;
        int stall_left;
        logic r, rdy;
        logic [5:0] op;
        logic [5:0] ops[7];
        int lat[7];

        tbl.push_back('{1, RT,   1, 0,  2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{1, RT,   1, 0,  2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{0, RT,   1, 0,  2'b00, 2'b00, 0, 1, 0, 0});
        tbl.push_back('{0, RT,   1, 1,  2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{0, RT,   1, 6,  2'b10, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{0, RT,   1, 7,  2'b00, 2'b00, 1, 0, 0, 0});
        tbl.push_back('{0, BEQ,  1, 0,  2'b00, 2'b00, 0, 1, 0, 0});
        tbl.push_back('{0, BEQ,  1, 1,  2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{0, BEQ,  1, 8,  2'b01, 2'b01, 0, 0, 1, 0});
        tbl.push_back('{0, JMP,  1, 0,  2'b00, 2'b00, 0, 1, 0, 0});
        tbl.push_back('{0, JMP,  1, 1,  2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{0, JMP,  1, 11, 2'b00, 2'b10, 0, 1, 0, 0});
        tbl.push_back('{0, ILL,  1, 0,  2'b00, 2'b00, 0, 1, 0, 0});
        tbl.push_back('{0, ILL,  1, 1,  2'b00, 2'b00, 0, 0, 0, 1});
        tbl.push_back('{0, LW,   0, 0,  2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{0, LW,   1, 0,  2'b00, 2'b00, 0, 1, 0, 0});
        tbl.push_back('{0, LW,   1, 1,  2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{0, LW,   1, 2,  2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{0, LW,   1, 3,  2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{0, LW,   1, 4,  2'b00, 2'b00, 1, 0, 0, 0});
        tbl.push_back('{0, ADDI, 1, 0,  2'b00, 2'b00, 0, 1, 0, 0});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].rdy);
            got  = {State, ALUOp, PCSrc, RegWrite, PCWrite, Branch, IllegalOp};
            want = {tbl[i].st, tbl[i].aop, tbl[i].pcs, tbl[i].rw, tbl[i].pcw,
                    tbl[i].br, tbl[i].ill};
            check($sformatf("vec%0d", i), 32'(got), 32'(want));
            if (tbl[i].rst) check($sformatf("vec%0d_reset_all_zero", i), 32'(obs), 32'd0);
            tick();
        end

        // finish the addi started by the last table row
        go_to(ADDI, 0);

        // lw with three stall cycles in MEMRD
        cyc = 0; n3 = 0; stray = 0; saw4 = 0;
        for (int k = 0; k < 40; k++) begin
            rdy = !(State == 4'd3 && n3 < 3);
            drive(0, LW, rdy);
            cyc++;
            if (State == 4'd3) n3++;
            if (MemWrite) stray++;
            if (RegWrite && State != 4'd4) stray++;
            if (State == 4'd4 && RegWrite && MemtoReg) saw4++;
            tick();
            if (State == 4'd0) break;
        end
        check("lw_stall_len", 32'(cyc), 32'd8);
        check("lw_memrd_cycles", 32'(n3), 32'd4);
        check("lw_stray_writes", 32'(stray), 32'd0);
        check("lw_memwb_write", 32'(saw4), 32'd1);

        // back-to-back latency with MemReady tied high
        ops = '{LW, SW, RT, ADDI, BEQ, JMP, ILL};
        lat = '{5, 4, 4, 4, 3, 3, 2};
        for (int i = 0; i < 7; i++) begin
            cyc = 0; stray = 0;
            do begin
                drive(0, ops[i], 1);
                if (State == 4'd1 && ops[i] == ILL) begin
                    check("illegal_pulse", 32'(IllegalOp), 32'd1);
                    if (MemRead || MemWrite || IRWrite || PCWrite || RegWrite || Branch)
                        stray++;
                end
                if (MemFault && IllegalOp) stray++;
                cyc++;
                tick();
            end while (State != 4'd0 && cyc < 50);
            check($sformatf("latency_op%02h", ops[i]), 32'(cyc), 32'(lat[i]));
            check($sformatf("latency_stray_op%02h", ops[i]), 32'(stray), 32'd0);
        end

        // sw timeout in MEMWR
        go_to(SW, 5);
        stall_until_fault("sw_timeout", SW, 5, TMO);
        drive(0, SW, 1);
        check("post_fault_quiet", 32'(MemFault), 32'd0);

        // sw with MemReady arriving exactly on the timeout cycle
        go_to(SW, 5);
        for (int idx = 0; idx <= TMO; idx++) begin
            drive(0, SW, (idx == TMO));
            if (idx == TMO) begin
                check("sw_late_ready_nofault", 32'(MemFault), 32'd0);
                check("sw_late_ready_write", 32'(MemWrite), 32'd1);
                check("sw_late_ready_state", 32'(State), 32'd5);
            end
            tick();
        end
        check("sw_late_ready_next", 32'(State), 32'd0);

        // FETCH timeout: no IR/PC load, stays in FETCH
        stall_until_fault("fetch_timeout", RT, 0, TMO);

        // reset while in MEMWB
        go_to(LW, 4);
        drive(1, LW, 1);
        check("reset_in_memwb_regwrite", 32'(RegWrite), 32'd0);
        check("reset_in_memwb_state", 32'(State), 32'd0);
        tick();
        drive(0, LW, 0);
        check("after_reset_state", 32'(State), 32'd0);
        // partial stall, reset, then a full timeout must need TMO fresh waits
        for (int i = 0; i < 5; i++) begin drive(0, LW, 0); tick(); end
        drive(1, LW, 0); tick();
        stall_until_fault("post_reset_counter", LW, 0, TMO);

        // randomized run against the model
        m_st = 0; m_wait = 0; stall_left = 0; op = RT;
        for (int n = 0; n < 4000; n++) begin
            r = (n == 0) || ($urandom_range(0, 199) == 0);
            if (m_st == 0) begin
                case ($urandom_range(0, 7))
                    0: op = LW;   1: op = SW;   2: op = RT;  3: op = BEQ;
                    4: op = ADDI; 5: op = JMP;  6: op = LW;
                    default: op = 6'($urandom_range(0, 63));
                endcase
            end
            if (stall_left > 0) begin
                rdy = 0; stall_left--;
            end else if ($urandom_range(0, 99) < 4) begin
                stall_left = $urandom_range(12, 20); rdy = 0;
            end else begin
                rdy = ($urandom_range(0, 99) < 70);
            end
            drive(r, op, rdy);
            check($sformatf("rand%0d", n), 32'(obs), 32'(model_out(m_st, r, op, rdy, m_wait)));
            model_step(r, op, rdy);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
